// File: rtl/nes_dma_pkg.sv
// rtl/nes_dma_pkg.sv - shared types and constants for the OAM DMA controller
package nes_dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_REG_ADDR = 16'h4014;
  localparam int          OAM_SIZE         = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - CPU-side OAM DMA initiator: stalls the CPU and copies one page into sprite OAM
module oam_dma_ctrl
  import nes_dma_pkg::*;
#(
  parameter int NUM_BYTES    = OAM_SIZE,
  parameter int DUMMY_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dma_reg_we,
  input  logic [7:0]  cpu_data_in,
  input  logic [7:0]  oam_start,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data_in,
  output logic        cpu_stall,
  output logic        oam_dma,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_out,
  output logic        busy
);

  // Byte counter is 8 bits wide, so the last index is the final byte of a 256-byte page.
  localparam logic [7:0] LAST_IDX  = 8'(NUM_BYTES - 1);
  localparam logic [7:0] HALT_LAST = 8'(DUMMY_CYCLES - 1);

  dma_state_t  state, state_nxt;
  logic        odd;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  dest;
  logic [7:0]  halt_cnt;
  logic [15:0] last_addr;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; HALT picks ALIGN when the following cycle would be odd,
  // so READ always lands on an even cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dma_reg_we) state_nxt = HALT;
      HALT:    if (halt_cnt == HALT_LAST) state_nxt = odd ? READ : ALIGN;
      ALIGN:   state_nxt = READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = (idx == LAST_IDX) ? IDLE : READ;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: parity toggle, source page, byte index, OAM destination and held read address.
  always_ff @(posedge clk) begin
    if (reset) begin
      odd       <= 1'b0;
      page      <= 8'h00;
      idx       <= 8'h00;
      dest      <= 8'h00;
      halt_cnt  <= 8'h00;
      last_addr <= 16'h0000;
    end else begin
      odd       <= ~odd;
      last_addr <= mem_addr;
      case (state)
        IDLE: begin
          if (dma_reg_we) begin
            page     <= cpu_data_in;
            dest     <= oam_start;
            idx      <= 8'h00;
            halt_cnt <= 8'h00;
          end
        end
        HALT:  halt_cnt <= halt_cnt + 8'd1;
        WRITE: begin
          dest <= dest + 8'd1;
          idx  <= idx + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; mem_addr keeps its last driven value outside READ.
  always_comb begin
    busy         = (state != IDLE);
    cpu_stall    = (state != IDLE);
    mem_rd       = 1'b0;
    mem_addr     = last_addr;
    oam_dma      = 1'b0;
    oam_addr     = 8'h00;
    oam_data_out = 8'h00;
    case (state)
      READ: begin
        mem_rd   = 1'b1;
        mem_addr = {page, idx};
      end
      WRITE: begin
        oam_dma      = 1'b1;
        oam_addr     = dest;
        oam_data_out = mem_data_in;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb/tb_oam_dma_ctrl.sv - scoreboard bench for oam_dma_ctrl
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dma_reg_we;
  logic [7:0]  cpu_data_in;
  logic [7:0]  oam_start;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_in;
  logic        cpu_stall;
  logic        oam_dma;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int stall_cnt = 0;
  int wr_cnt = 0;
  int cyc = 0;
  logic prev_dma = 1'b0;

  logic [15:0] exp_rd[$];
  logic [15:0] exp_wr[$];

  oam_dma_ctrl dut (
    .clk(clk), .reset(reset), .dma_reg_we(dma_reg_we), .cpu_data_in(cpu_data_in),
    .oam_start(oam_start), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .cpu_stall(cpu_stall), .oam_dma(oam_dma), .oam_addr(oam_addr),
    .oam_data_out(oam_data_out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return (a[7:0] * 8'd3) ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle parity since reset: cycle 0 after reset is even.
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // CPU memory model: data valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) mem_data_in <= mem_byte(mem_addr);
  end

  // Monitor: scoreboard pops on reads and OAM writes.
  always @(negedge clk) begin
    if (!reset) begin
      if (cpu_stall) stall_cnt++;
      if (mem_rd) begin
        check("rd_even", 32'(cyc[0]), 32'd0);
        if (exp_rd.size() == 0) check("rd_extra", 32'd1, 32'd0);
        else check("rd_addr", 32'(mem_addr), 32'(exp_rd.pop_front()));
      end
      if (oam_dma) begin
        logic [15:0] e;
        wr_cnt++;
        if (prev_dma) check("dma_b2b", 32'd1, 32'd0);
        if (exp_wr.size() == 0) check("wr_extra", 32'd1, 32'd0);
        else begin
          e = exp_wr.pop_front();
          if (oam_addr !== e[15:8] || oam_data_out !== e[7:0])
            check("wr_addr_data", 32'({oam_addr, oam_data_out}), 32'(e));
          else checks++;
        end
      end
    end
    prev_dma = oam_dma;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [7:0] page, input logic [7:0] start);
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      a = {page, 8'(i)};
      d = start + 8'(i);
      exp_rd.push_back(a);
      exp_wr.push_back({d, mem_byte(a)});
    end
  endtask

  task automatic trigger(input logic [7:0] page, input logic [7:0] start, input logic par);
    int n;
    n = 0;
    while (cyc[0] !== par && n < 4) begin
      step();
      n++;
    end
    cpu_data_in = page;
    oam_start   = start;
    dma_reg_we  = 1'b1;
    step();
    dma_reg_we  = 1'b0;
  endtask

  task automatic run_xfer(input string name, input logic [7:0] page, input logic [7:0] start,
                          input logic par, input int retrig_at, input logic [7:0] retrig_page);
    int k;
    int exp_stall;
    exp_stall = par ? 514 : 513;
    stall_cnt = 0;
    wr_cnt = 0;
    push_expect(page, start);
    trigger(page, start, par);
    check({name, "_stall_rise"}, 32'(cpu_stall), 32'd1);
    k = 1;
    while (busy && k < 3000) begin
      if (k == retrig_at) begin
        cpu_data_in = retrig_page;
        dma_reg_we  = 1'b1;
      end
      step();
      dma_reg_we = 1'b0;
      k++;
    end
    check({name, "_timeout"}, 32'(k < 3000), 32'd1);
    check({name, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    check({name, "_writes"}, 32'(wr_cnt), 32'd256);
    check({name, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
    check({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    repeat (5) step();
    check({name, "_idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    dma_reg_we = 1'b0;
    cpu_data_in = 8'h00;
    oam_start = 8'h00;
    mem_data_in = 8'h00;
    repeat (3) step();
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_dma", 32'(oam_dma), 32'd0);
    check("rst_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_oam_addr", 32'(oam_addr), 32'd0);
    check("rst_oam_data", 32'(oam_data_out), 32'd0);
    reset = 1'b0;
    step();

    run_xfer("even", 8'h02, 8'h00, 1'b0, 0, 8'h00);
    run_xfer("odd", 8'h02, 8'h00, 1'b1, 0, 8'h00);
    run_xfer("offset", 8'h03, 8'hF0, 1'b0, 0, 8'h00);
    run_xfer("retrig", 8'h02, 8'h00, 1'b0, 100, 8'h07);
    run_xfer("lastwr_we", 8'h04, 8'h10, 1'b1, 514, 8'h09);
    run_xfer("page_ff", 8'hFF, 8'h00, 1'b0, 0, 8'h00);

    // Reset after 40 OAM writes.
    stall_cnt = 0;
    wr_cnt = 0;
    push_expect(8'h02, 8'h00);
    trigger(8'h02, 8'h00, 1'b0);
    n = 0;
    while (wr_cnt < 40 && n < 2000) begin
      step();
      n++;
    end
    check("mid_reach40", 32'(wr_cnt), 32'd40);
    reset = 1'b1;
    step();
    check("mid_rst_stall", 32'(cpu_stall), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_dma", 32'(oam_dma), 32'd0);
    reset = 1'b0;
    exp_rd.delete();
    exp_wr.delete();
    repeat (20) step();
    check("mid_no_more_wr", 32'(wr_cnt), 32'd40);
    check("mid_idle", 32'(busy), 32'd0);
    run_xfer("after_rst", 8'h05, 8'h00, 1'b0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
CPU-side initiator for the PPU's OAM DMA port: the agent that drives oam_dma, oam_addr and oam_data_in on the PPU top level.
- A CPU write to $4014 supplies a source page.
- The block stalls the CPU, copies 256 bytes from CPU address space {page, 8'h00}..{page, 8'hFF} into sprite OAM, then releases the CPU.
- It sits between the CPU bus decoder, CPU work RAM and the PPU.

Parameters:
NUM_BYTES, 256, bytes per transfer (counter width fixed at 8 bits; 256 only legal value for now)
DUMMY_CYCLES, 1, halt cycles inserted before alignment check

Ports:
clk  input  1  system clock (one CPU cycle per clk)
reset  input  1  synchronous, active-high reset
dma_reg_we  input  1  decoded CPU write strobe to $4014, one cycle wide
cpu_data_in  input  8  CPU write data; source page latched on dma_reg_we
oam_start  input  8  current OAMADDR from ppu_reg; first OAM destination
mem_rd  output  1  read request to CPU memory
mem_addr  output  16  CPU memory read address
mem_data_in  input  8  CPU memory read data, valid one cycle after mem_rd
cpu_stall  output  1  high while CPU must not advance (RDY low)
oam_dma  output  1  OAM write strobe to PPU
oam_addr  output  8  OAM write address
oam_data_out  output  8  OAM write data
busy  output  1  transfer in progress

Behaviour:
- Reset values: all outputs 0; state IDLE; parity flag 0; page, idx and dest registers 0.
- Parity: `odd` toggles every clk from reset. A cycle is "even" when odd==0.
- States:
  - IDLE: on dma_reg_we, latch page<=cpu_data_in, dest<=oam_start, idx<=0, then go to HALT.
  - HALT: lasts DUMMY_CYCLES cycles. Exit to ALIGN if odd==1 on the final halt cycle's successor; otherwise exit to READ.
  - ALIGN: exactly 1 cycle, then READ. Guarantees READ is always entered on an even cycle.
  - READ: mem_rd=1, mem_addr={page, idx}; next state WRITE.
  - WRITE: oam_dma=1, oam_addr=dest, oam_data_out=mem_data_in (registered pass-through of the data returned for the preceding READ). dest<=dest+1 (mod 256), idx<=idx+1.
    - If idx==8'hFF, go to IDLE.
    - Otherwise go to READ.
- cpu_stall and busy: high in every non-IDLE state. Combinational from state, so cpu_stall rises the cycle after dma_reg_we.
- Total stall: DUMMY_CYCLES + 512 (+1 if aligned) = 513 or 514 cycles with defaults.
- Exactly 256 oam_dma pulses per transfer. oam_dma is never asserted in consecutive cycles.
- dest wraps 8'hFF->8'h00. A non-zero oam_start therefore wraps within OAM; no bytes are dropped.
- page 8'hFF: mem_addr spans 16'hFF00-16'hFFFF; no special case.
- dma_reg_we while busy: ignored; page and dest are unchanged.
- dma_reg_we in the same cycle as a WRITE of the final byte: ignored (state still non-IDLE that cycle).
- reset mid-transfer: next cycle state=IDLE and all outputs 0. No further oam_dma pulses. A partially written OAM is acceptable.
- mem_rd is asserted only in READ. mem_addr holds its last value otherwise; verification must not check mem_addr when mem_rd=0.

Decomposition:
- Shared package `nes_dma_pkg`:
  - state enum dma_state_t {IDLE, HALT, ALIGN, READ, WRITE}
  - constant OAM_DMA_REG_ADDR = 16'h4014
  - constant OAM_SIZE = 256
- Sub-module: none required. Parity toggle and byte counter are inline.

Test Plan:
- Even-aligned trigger: reset, dma_reg_we with cpu_data_in=8'h02 and oam_start=0, such that HALT lands with odd==0 after it. Required: cpu_stall high 513 cycles; mem_addr sweeps 16'h0200..16'h02FF; 256 oam_dma pulses with oam_addr 0..255; oam_data_out matches memory model.
- Odd-aligned trigger: same as the even-aligned case, but trigger one cycle later. Required: one ALIGN cycle; stall exactly 514 cycles; first mem_rd on an even cycle.
- OAMADDR offset: oam_start=8'hF0, page 8'h03. Required: first write oam_addr=8'hF0 with data from 16'h0300. The write with data from 16'h0310 has oam_addr=8'h00. The final write has oam_addr=8'hEF.
- Retrigger while busy: second dma_reg_we with cpu_data_in=8'h07 at transfer cycle 100. Required: page stays 8'h02; still 256 writes; total stall unchanged.
- Reset mid-transfer: assert reset after 40 oam_dma pulses. Required: the next cycle has cpu_stall=0, busy=0, oam_dma=0; no further writes. A fresh dma_reg_we afterwards performs a full 256-byte transfer.
- Page 8'hFF boundary: cpu_data_in=8'hFF. Required: last mem_addr=16'hFFFF; no address wrap into page 8'h00; stall returns low after the final write.
